dmem_sram_bridge: RTL and testbench

//  Sits directly downstream of the datapath Memory stage.

---
 rtl/mips_bus_pkg.sv | 23 ++
 rtl/bus_req_reg.sv | 59 +++++
 rtl/dmem_sram_bridge.sv | 140 ++++++++++++++
 tb/tb_dmem_sram_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// ============================================================================
// Module  : mips_bus_pkg
// Brief   : Shared encodings for the data-memory SRAM-like bus bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } busState_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/bus_req_reg.sv
// ============================================================================
// Module  : bus_req_reg
// Brief   : Holds the request fields of the in-flight bus access.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_req_reg #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_wr,
    output logic [1:0]        o_size,
    output logic [STRB_W-1:0] o_wstrb,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata
);

    logic              r_wr;
    logic [1:0]        r_size;
    logic [STRB_W-1:0] r_wstrb;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    // Fields only change on IDLE->ADDR, so they stay put until addr_ok.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_wstrb <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (i_load) begin
            r_wr    <= i_wr;
            r_size  <= i_size;
            r_wstrb <= i_wstrb;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end
    end

    assign o_wr    = r_wr;
    assign o_size  = r_size;
    assign o_wstrb = r_wstrb;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;

endmodule

`default_nettype wire

// File: rtl/dmem_sram_bridge.sv
// ============================================================================
// Module  : dmem_sram_bridge
// Brief   : M-stage data access to SRAM-like req/addr_ok/data_ok bus bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_sram_bridge
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic [STRB_W-1:0] mem_wstrb,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              advance,
    input  logic              flush,
    output logic [DATA_W-1:0] readdata,
    output logic              stall_mem,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [STRB_W-1:0] data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    busState_t         r_state;
    busState_t         w_nextState;
    logic              r_discard;
    logic              w_nextDiscard;
    logic [DATA_W-1:0] r_readdata;
    logic              w_load;
    logic              w_capture;
    logic              w_kill;

    bus_req_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .STRB_W (STRB_W)
    ) u_bus_req_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_wr    (mem_wr),
        .i_size  (mem_size),
        .i_wstrb (mem_wstrb),
        .i_addr  (mem_addr),
        .i_wdata (mem_wdata),
        .o_wr    (data_wr),
        .o_size  (data_size),
        .o_wstrb (data_wstrb),
        .o_addr  (data_addr),
        .o_wdata (data_wdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_discard  <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_state   <= w_nextState;
            r_discard <= w_nextDiscard;
            if (w_capture) begin
                r_readdata <= data_rdata;
            end
        end
    end

    // A flush in the same cycle as data_ok kills the response just like a
    // flush seen earlier in the transaction.
    assign w_kill = r_discard | flush;

    always_comb begin
        w_nextState   = r_state;
        w_nextDiscard = r_discard;
        w_load        = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_en && !flush) begin
                    w_nextState = ADDR;
                    w_load      = 1'b1;
                end
            end
            ADDR: begin
                if (flush) begin
                    w_nextDiscard = 1'b1;
                end
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        w_nextState = w_kill ? IDLE : HOLD;
                        w_capture   = !w_kill && !data_wr;
                    end else begin
                        w_nextState = DATA;
                    end
                end
            end
            DATA: begin
                if (flush) begin
                    w_nextDiscard = 1'b1;
                end
                if (data_data_ok) begin
                    w_nextState = w_kill ? IDLE : HOLD;
                    w_capture   = !w_kill && !data_wr;
                end
            end
            HOLD: begin
                if (advance || flush) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (w_nextState == IDLE) begin
            w_nextDiscard = 1'b0;
        end
    end

    assign stall_mem = (mem_en && !flush && (r_state != HOLD))
                     || (((r_state == ADDR) || (r_state == DATA)) && !r_discard);
    assign data_req  = (r_state == ADDR);
    assign readdata  = r_readdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_sram_bridge.sv
// ============================================================================
// Module  : tb_dmem_sram_bridge
// Brief   : Self-checking bench for dmem_sram_bridge with a variable-latency slave.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_sram_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_en;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        advance;
    logic        flush;
    logic [31:0] readdata;
    logic        stall_mem;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    always #5 clk = ~clk;

    dmem_sram_bridge #(
        .ADDR_W (32),
        .DATA_W (32),
        .STRB_W (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .advance      (advance),
        .flush        (flush),
        .readdata     (readdata),
        .stall_mem    (stall_mem),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aw;        // cycles addr_ok is withheld
        int          dw;        // cycles from addr_ok to data_ok (0 = same cycle)
        int          hold;      // extra HOLD cycles without advance
        logic [31:0] expRead;
        int          expStall;
        int          expReq;
    } vec_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } busReq_t;

    vec_t    vecs [7];
    busReq_t sbq [$];
    int      errors = 0;
    int      checks = 0;
    int      sPhase;
    int      sCnt;
    int      sAw;
    int      sDw;
    logic [31:0] sRdata;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive pipeline controls and slave handshakes at the
    // falling edge, then compare any visible request with the scoreboard.
    task automatic step(input logic en, input logic fl);
        busReq_t cur;
        @(negedge clk);
        mem_en       = en;
        flush        = fl;
        advance      = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = sRdata;
        if (sPhase == 0 && data_req) begin
            if (sCnt == sAw) begin
                data_addr_ok = 1'b1;
                sCnt         = 0;
                if (sDw == 0) begin
                    data_data_ok = 1'b1;
                end else begin
                    sPhase = 1;
                    sCnt   = 1;
                end
            end else begin
                sCnt++;
            end
        end else if (sPhase == 1) begin
            if (sCnt == sDw) begin
                data_data_ok = 1'b1;
                sPhase       = 0;
                sCnt         = 0;
            end else begin
                sCnt++;
            end
        end
        #1;
        if (data_req) begin
            cur = '{data_wr, data_size, data_wstrb, data_addr, data_wdata};
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got req=1 expected req=0 addr=%h", data_addr);
            end else begin
                check("req_fields", cur, sbq[0]);
                if (data_addr_ok) begin
                    void'(sbq.pop_front());
                end
            end
        end
    endtask

    task automatic startTxn(input vec_t v);
        sAw       = v.aw;
        sDw       = v.dw;
        sRdata    = v.rdata;
        sPhase    = 0;
        sCnt      = 0;
        mem_wr    = v.wr;
        mem_size  = v.size;
        mem_wstrb = v.wstrb;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        sbq.push_back('{v.wr, v.size, v.wstrb, v.addr, v.wdata});
    endtask

    task automatic runTxn(input vec_t v, input int idx);
        int  stallCnt = 0;
        int  reqCnt   = 0;
        int  holdCnt  = 0;
        bit  done     = 0;
        startTxn(v);
        for (int c = 0; c < 40 && !done; c++) begin
            step(1'b1, 1'b0);
            if (data_req) reqCnt++;
            if (stall_mem) begin
                stallCnt++;
            end else begin
                check($sformatf("v%0d_readdata", idx), readdata, v.expRead);
                check($sformatf("v%0d_hold_req", idx), data_req, 1'b0);
                if (holdCnt < v.hold) begin
                    holdCnt++;
                end else begin
                    advance = 1'b1;
                    done    = 1;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL v%0d_timeout: got no completion expected HOLD within 40 cycles", idx);
        end
        check($sformatf("v%0d_stall_cycles", idx), stallCnt, v.expStall);
        check($sformatf("v%0d_req_cycles", idx), reqCnt, v.expReq);
        check($sformatf("v%0d_sb_empty", idx), sbq.size(), 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'd2, 4'b0000, 32'h8000_1000, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 32'hDEAD_BEEF, 4, 1};
        vecs[1] = '{1'b1, 2'd0, 4'b0100, 32'h8000_1002, 32'h00AB_0000, 32'h1111_1111, 0, 0, 0, 32'hDEAD_BEEF, 2, 1};
        vecs[2] = '{1'b0, 2'd1, 4'b0000, 32'h8000_2004, 32'h0, 32'h0000_CAFE, 5, 1, 0, 32'h0000_CAFE, 8, 6};
        vecs[3] = '{1'b0, 2'd2, 4'b0000, 32'h8000_2008, 32'h0, 32'hA5A5_A5A5, 1, 0, 4, 32'hA5A5_A5A5, 3, 2};
        vecs[4] = '{1'b1, 2'd2, 4'b1111, 32'h8000_200C, 32'h0102_0304, 32'h2222_2222, 2, 3, 0, 32'hA5A5_A5A5, 7, 3};
        vecs[5] = '{1'b0, 2'd0, 4'b0000, 32'h8000_2011, 32'h0, 32'h0000_007F, 0, 0, 0, 32'h0000_007F, 2, 1};
        vecs[6] = '{1'b1, 2'd1, 4'b1100, 32'h8000_2012, 32'hBEEF_0000, 32'h3333_3333, 3, 0, 2, 32'h0000_007F, 5, 4};

        reset = 1'b1; mem_en = 1'b0; mem_wr = 1'b0; mem_size = 2'd0; mem_wstrb = 4'd0;
        mem_addr = 32'd0; mem_wdata = 32'd0; advance = 1'b0; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        sPhase = 0; sCnt = 0; sAw = 0; sDw = 0; sRdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", data_req, 1'b0);
        check("rst_stall", stall_mem, 1'b0);
        check("rst_readdata", readdata, 32'd0);
        check("rst_bus", {data_wr, data_size, data_wstrb, data_addr, data_wdata}, 80'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            runTxn(vecs[i], i);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check("idle_req", data_req, 1'b0);
            check("idle_stall", stall_mem, 1'b0);
        end

        // Flush while waiting in DATA: the late response must be dropped.
        startTxn('{1'b0, 2'd2, 4'b0000, 32'h8000_3000, 32'h0, 32'h1234_5678, 0, 3, 0, 32'h0, 0, 0});
        step(1'b1, 1'b0);
        check("fl_idle_stall", stall_mem, 1'b1);
        step(1'b1, 1'b0);
        check("fl_addr_req", data_req, 1'b1);
        step(1'b1, 1'b1);
        check("fl_data_req", data_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check("fl_drain_stall", stall_mem, 1'b0);
            check("fl_drain_req", data_req, 1'b0);
        end
        check("fl_readdata", readdata, 32'h0000_007F);
        check("fl_sb_empty", sbq.size(), 0);
        runTxn(vecs[0], 10);

        // Reset in the middle of a transaction.
        startTxn('{1'b0, 2'd2, 4'b0000, 32'h8000_4000, 32'h0, 32'h55AA_55AA, 0, 5, 0, 32'h0, 0, 0});
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1; mem_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        check("mid_rst_req", data_req, 1'b0);
        check("mid_rst_stall", stall_mem, 1'b0);
        check("mid_rst_readdata", readdata, 32'd0);
        check("mid_rst_bus", {data_wr, data_size, data_wstrb, data_addr, data_wdata}, 80'd0);
        sbq.delete();
        sPhase = 0;
        sCnt   = 0;
        @(negedge clk);
        reset = 1'b0;
        runTxn(vecs[3], 11);
        step(1'b0, 1'b0);
        check("end_req", data_req, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
